// File: rtl/frame_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_write_sequencer
// Purpose  : ray-marcher pixel stream -> linear framebuffer writes, with the
//            buffer swap issued only after the finished frame is fully written.
//            Define FRAME_WRITE_VSYNC_SWAP_EN to hold the swap until vblank_in.
// Revision : 1.0
// ============================================================================
module frame_write_sequencer #(
   parameter int DISPLAY_WIDTH  = 320,
   parameter int DISPLAY_HEIGHT = 240,
   parameter int H_BITS         = 9,
   parameter int V_BITS         = 8,
   parameter int ADDR_BITS      = 17,
   parameter int COLOR_BITS     = 4,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [H_BITS-1:0]     hcount_in,
   input  logic [V_BITS-1:0]     vcount_in,
   input  logic [COLOR_BITS-1:0] color_in,
   input  logic                  valid_in,
   input  logic                  new_frame_in,
   input  logic                  vblank_in,
   output logic                  write_enable_out,
   output logic [ADDR_BITS-1:0]  write_addr_out,
   output logic [COLOR_BITS-1:0] write_data_out,
   output logic                  swap_out,
   output logic                  which_buf_out,
   output logic                  swap_pending_out,
   output logic                  overrun_out,
   output logic [15:0]           drop_count_out
);

   localparam int c_PW = $clog2(FIFO_DEPTH);
   localparam int c_CW = c_PW + 1;
   localparam int c_EW = ADDR_BITS + COLOR_BITS;

   typedef enum logic [1:0] {
      ST_STREAM      = 2'd0,
      ST_DRAIN       = 2'd1,
      ST_WAIT_VBLANK = 2'd2,
      ST_SWAP        = 2'd3
   } state_t;

   // stage 0
   logic                  w_in_range;
   logic                  w_range_drop;
   logic [ADDR_BITS-1:0]  w_addr;
   logic                  r_s0_valid;
   logic                  r_s0_nf;
   logic [ADDR_BITS-1:0]  r_s0_addr;
   logic [COLOR_BITS-1:0] r_s0_color;

   // fifo
   logic [c_EW-1:0]       r_mem [FIFO_DEPTH];
   logic [c_PW-1:0]       r_wr_ptr;
   logic [c_PW-1:0]       r_rd_ptr;
   logic [c_CW-1:0]       r_count;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_gate;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_fifo_drop;
   logic [16:0]           w_drop_sum;

   // control / outputs
   state_t                r_state;
   logic [c_CW-1:0]       r_bcount;
   logic                  w_swap_ready;
   logic                  r_we;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [COLOR_BITS-1:0] r_data;
   logic                  r_swap;
   logic                  r_which;
   logic                  r_pending;
   logic                  r_overrun;
   logic [15:0]           r_drop;

   assign w_in_range   = (32'(hcount_in) < DISPLAY_WIDTH) && (32'(vcount_in) < DISPLAY_HEIGHT);
   assign w_range_drop = valid_in && !w_in_range;
   assign w_addr       = ADDR_BITS'(vcount_in) * ADDR_BITS'(DISPLAY_WIDTH) + ADDR_BITS'(hcount_in);

`ifdef FRAME_WRITE_VSYNC_SWAP_EN
   assign w_swap_ready = vblank_in;
`else
   // vblank_in has no effect in this build; the swap follows the last write
   assign w_swap_ready = vblank_in | 1'b1;
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_s0_valid <= 1'b0;
         r_s0_nf    <= 1'b0;
         r_s0_addr  <= '0;
         r_s0_color <= '0;
      end else begin
         r_s0_valid <= valid_in && w_in_range;
         r_s0_nf    <= new_frame_in;
         r_s0_addr  <= w_addr;
         r_s0_color <= color_in;
      end
   end

   always_comb begin
      w_gate = 1'b0;
      case (r_state)
         ST_STREAM: w_gate = 1'b1;
         ST_DRAIN:  w_gate = (r_bcount != '0);
         default:   w_gate = 1'b0;
      endcase
   end

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_CW'(FIFO_DEPTH));
   assign w_pop       = !w_empty && w_gate;
   assign w_push      = r_s0_valid && (!w_full || w_pop);
   assign w_fifo_drop = r_s0_valid && w_full && !w_pop;
   assign w_drop_sum  = {1'b0, r_drop} + 17'(w_range_drop) + 17'(w_fifo_drop);

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_s0_addr, r_s0_color};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_drop   <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PW'(1);
            {r_addr, r_data} <= r_mem[r_rd_ptr];
         end
         r_we    <= w_pop;
         r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         r_drop  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

   // Boundary count excludes the pixel pushed alongside new_frame: it belongs to the next frame.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state   <= ST_STREAM;
         r_bcount  <= '0;
         r_swap    <= 1'b0;
         r_which   <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_swap <= 1'b0;
         case (r_state)
            ST_STREAM: begin
               if (r_s0_nf) begin
                  r_state   <= ST_DRAIN;
                  r_pending <= 1'b1;
                  r_bcount  <= r_count - c_CW'(w_pop);
               end
            end
            ST_DRAIN: begin
               if (r_s0_nf) begin
                  r_overrun <= 1'b1;
               end
               if (r_bcount != '0) begin
                  if (w_pop) begin
                     r_bcount <= r_bcount - c_CW'(1);
                  end
               end else begin
`ifdef FRAME_WRITE_VSYNC_SWAP_EN
                  r_state <= ST_WAIT_VBLANK;
`else
                  if (w_swap_ready) begin
                     r_state   <= ST_SWAP;
                     r_swap    <= 1'b1;
                     r_which   <= ~r_which;
                     r_pending <= 1'b0;
                  end
`endif
               end
            end
            ST_WAIT_VBLANK: begin
               if (r_s0_nf) begin
                  r_overrun <= 1'b1;
               end
               if (w_swap_ready) begin
                  r_state   <= ST_SWAP;
                  r_swap    <= 1'b1;
                  r_which   <= ~r_which;
                  r_pending <= 1'b0;
               end
            end
            ST_SWAP: begin
               if (r_s0_nf) begin
                  r_overrun <= 1'b1;
               end
               r_state <= ST_STREAM;
            end
            default: r_state <= ST_STREAM;
         endcase
      end
   end

   assign write_enable_out = r_we;
   assign write_addr_out   = r_addr;
   assign write_data_out   = r_data;
   assign swap_out         = r_swap;
   assign which_buf_out    = r_which;
   assign swap_pending_out = r_pending;
   assign overrun_out      = r_overrun;
   assign drop_count_out   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_frame_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_write_sequencer
// Purpose  : directed self-checking bench for frame_write_sequencer.
// Revision : 1.0
// ============================================================================
module tb_frame_write_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [8:0]  hcount_in;
   logic [7:0]  vcount_in;
   logic [3:0]  color_in;
   logic        valid_in;
   logic        new_frame_in;
   logic        vblank_in;
   logic        write_enable_out;
   logic [16:0] write_addr_out;
   logic [3:0]  write_data_out;
   logic        swap_out;
   logic        which_buf_out;
   logic        swap_pending_out;
   logic        overrun_out;
   logic [15:0] drop_count_out;

   int   errors = 0;
   int   checks = 0;
   logic exp_which;
   int   exp_drop;
   int   nsw;

   frame_write_sequencer #(
      .DISPLAY_WIDTH (320),
      .DISPLAY_HEIGHT(240),
      .H_BITS        (9),
      .V_BITS        (8),
      .ADDR_BITS     (17),
      .COLOR_BITS    (4),
      .FIFO_DEPTH    (16)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .color_in        (color_in),
      .valid_in        (valid_in),
      .new_frame_in    (new_frame_in),
      .vblank_in       (vblank_in),
      .write_enable_out(write_enable_out),
      .write_addr_out  (write_addr_out),
      .write_data_out  (write_data_out),
      .swap_out        (swap_out),
      .which_buf_out   (which_buf_out),
      .swap_pending_out(swap_pending_out),
      .overrun_out     (overrun_out),
      .drop_count_out  (drop_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int addr, input int data);
      check({tag, "_we"}, 32'(write_enable_out), 1);
      check({tag, "_addr"}, 32'(write_addr_out), addr);
      check({tag, "_data"}, 32'(write_data_out), data);
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, "_we"}, 32'(write_enable_out), 0);
      check({tag, "_addr"}, 32'(write_addr_out), 0);
      check({tag, "_data"}, 32'(write_data_out), 0);
      check({tag, "_swap"}, 32'(swap_out), 0);
      check({tag, "_which"}, 32'(which_buf_out), 0);
      check({tag, "_pend"}, 32'(swap_pending_out), 0);
      check({tag, "_ovr"}, 32'(overrun_out), 0);
      check({tag, "_drop"}, 32'(drop_count_out), 0);
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic v, input int h, input int vc, input int c);
      valid_in  = v;
      hcount_in = 9'(h);
      vcount_in = 8'(vc);
      color_in  = 4'(c);
   endtask

   initial begin
      rst_in       = 1'b0;
      new_frame_in = 1'b0;
      vblank_in    = 1'b0;
      drive(1'b0, 0, 0, 0);
      exp_which    = 1'b0;
      exp_drop     = 0;
      tick();
      tick();
      chk_all_zero("reset");
      rst_in = 1'b1;
      tick();

      // single pixel: write three cycles after it is presented
      drive(1'b1, 5, 2, 4'hA);
      tick();
      drive(1'b0, 0, 0, 0);
      check("t1_c1_we", 32'(write_enable_out), 0);
      tick();
      check("t1_c2_we", 32'(write_enable_out), 0);
      tick();
      chk_wr("t1_wr", 645, 4'hA);
      tick();
      check("t1_we_low", 32'(write_enable_out), 0);
      check("t1_addr_hold", 32'(write_addr_out), 645);

      // out-of-range pixels are dropped and counted
      drive(1'b1, 320, 0, 3);
      tick();
      drive(1'b0, 0, 0, 0);
      repeat (3) begin
         tick();
         check("rng_h_no_wr", 32'(write_enable_out), 0);
      end
      exp_drop++;
      check("rng_h_drop", 32'(drop_count_out), exp_drop);
      drive(1'b1, 0, 240, 3);
      tick();
      drive(1'b0, 0, 0, 0);
      repeat (3) begin
         tick();
         check("rng_v_no_wr", 32'(write_enable_out), 0);
      end
      exp_drop++;
      check("rng_v_drop", 32'(drop_count_out), exp_drop);
      drive(1'b1, 319, 239, 7);
      tick();
      drive(1'b0, 0, 0, 0);
      tick();
      tick();
      chk_wr("rng_edge_wr", 76799, 7);
      check("rng_edge_drop", 32'(drop_count_out), exp_drop);

`ifndef FRAME_WRITE_VSYNC_SWAP_EN
      // four pixels then new_frame: swap the cycle after the 4th write
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i, 10, i + 1);
         tick();
         if (i >= 2) chk_wr("f4_wr", 3200 + i - 2, i - 1);
      end
      drive(1'b0, 0, 0, 0);
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      chk_wr("f4_wr2", 3202, 3);
      check("f4_pend_early", 32'(swap_pending_out), 0);
      tick();
      chk_wr("f4_wr3", 3203, 4);
      check("f4_pend", 32'(swap_pending_out), 1);
      check("f4_swap_early", 32'(swap_out), 0);
      tick();
      exp_which = ~exp_which;
      check("f4_swap", 32'(swap_out), 1);
      check("f4_which", 32'(which_buf_out), 32'(exp_which));
      check("f4_pend_clr", 32'(swap_pending_out), 0);
      check("f4_we_idle", 32'(write_enable_out), 0);
      tick();
      check("f4_swap_once", 32'(swap_out), 0);
`endif

      // eight pixels, then a ninth presented with new_frame (belongs to next frame)
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 10 + i, 20, i);
         tick();
         if (i >= 2) chk_wr("f8_wr", 6410 + i - 2, i - 2);
      end
      drive(1'b1, 100, 20, 4'hF);
      new_frame_in = 1'b1;
      tick();
      drive(1'b0, 0, 0, 0);
      new_frame_in = 1'b0;
      chk_wr("f8_wr6", 6416, 6);
      tick();
      chk_wr("f8_wr7", 6417, 7);
      check("f8_pend", 32'(swap_pending_out), 1);
`ifdef FRAME_WRITE_VSYNC_SWAP_EN
      repeat (3) begin
         tick();
         check("f8_hold_we", 32'(write_enable_out), 0);
         check("f8_hold_swap", 32'(swap_out), 0);
         check("f8_hold_pend", 32'(swap_pending_out), 1);
      end
      vblank_in = 1'b1;
      tick();
      vblank_in = 1'b0;
      exp_which = ~exp_which;
      check("f8_swap", 32'(swap_out), 1);
      check("f8_which", 32'(which_buf_out), 32'(exp_which));
      check("f8_pend_clr", 32'(swap_pending_out), 0);
      tick();
      check("f8_swap_once", 32'(swap_out), 0);
      check("f8_no_wr", 32'(write_enable_out), 0);
      tick();
      chk_wr("f8_ninth", 6500, 4'hF);

      // hold in WAIT_VBLANK while overfilling the FIFO
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      tick();
      check("ov_pend", 32'(swap_pending_out), 1);
      tick();
      for (int j = 0; j < 19; j++) begin
         drive(1'b1, j, 50, j);
         tick();
         check("ov_no_wr", 32'(write_enable_out), 0);
      end
      drive(1'b0, 0, 0, 0);
      tick();
      exp_drop += 3;
      check("ov_drop", 32'(drop_count_out), exp_drop);
      vblank_in = 1'b1;
      tick();
      vblank_in = 1'b0;
      exp_which = ~exp_which;
      check("ov_swap", 32'(swap_out), 1);
      check("ov_which", 32'(which_buf_out), 32'(exp_which));
      tick();
      for (int k = 0; k < 16; k++) begin
         tick();
         chk_wr("ov_wr", 16000 + k, k);
      end
      tick();
      check("ov_wr_end", 32'(write_enable_out), 0);
`else
      tick();
      exp_which = ~exp_which;
      check("f8_swap", 32'(swap_out), 1);
      check("f8_which", 32'(which_buf_out), 32'(exp_which));
      check("f8_pend_clr", 32'(swap_pending_out), 0);
      check("f8_no_wr", 32'(write_enable_out), 0);
      tick();
      check("f8_swap_once", 32'(swap_out), 0);
      check("f8_no_wr2", 32'(write_enable_out), 0);
      tick();
      chk_wr("f8_ninth", 6500, 4'hF);
`endif

      // second new_frame while a swap is pending -> overrun, single swap
      vblank_in    = 1'b1;
      new_frame_in = 1'b1;
      tick();
      tick();
      new_frame_in = 1'b0;
      check("orun_pend", 32'(swap_pending_out), 1);
      check("orun_early", 32'(overrun_out), 0);
      nsw = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (swap_out === 1'b1) nsw++;
      end
      vblank_in = 1'b0;
      exp_which = ~exp_which;
      check("orun_nswap", 32'(nsw), 1);
      check("orun_flag", 32'(overrun_out), 1);
      check("orun_pend_clr", 32'(swap_pending_out), 0);
      check("orun_which", 32'(which_buf_out), 32'(exp_which));

      // reset asserted while in DRAIN
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i, 30, i + 8);
         tick();
      end
      drive(1'b0, 0, 0, 0);
      new_frame_in = 1'b1;
      tick();
      new_frame_in = 1'b0;
      tick();
      check("rd_pend_pre", 32'(swap_pending_out), 1);
      chk_wr("rd_wr_pre", 9602, 10);
      rst_in = 1'b0;
      #1;
      chk_all_zero("rd_async");
      tick();
      tick();
      rst_in = 1'b1;
      exp_which = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("rd_post_swap", 32'(swap_out), 0);
         check("rd_post_we", 32'(write_enable_out), 0);
         check("rd_post_pend", 32'(swap_pending_out), 0);
      end
      drive(1'b1, 7, 1, 5);
      tick();
      drive(1'b0, 0, 0, 0);
      tick();
      tick();
      chk_wr("rd_first_wr", 327, 5);
      check("rd_which", 32'(which_buf_out), 32'(exp_which));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
